// File: rtl/fp_align_serial.sv
// fp_align_serial: pre-add operand alignment; swaps to put the larger exponent first and
// serially right-shifts the smaller mantissa by the exponent difference.
//   clk, rst_n (async, active-low)
//   In_valid/In_ready         operand handshake; A_exp/A_frac, B_exp/B_frac operands
//   Out_valid/Out_ready       result handshake
//   Final_exp                 max exponent; Big_frac/Small_frac aligned mantissas with hidden 1
//   Sticky                    OR of bits shifted out; Swapped = B larger; Invalid = all-ones exponent
module fp_align_serial #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [EXP_W-1:0]  A_exp,
  input  logic [FRAC_W-1:0] A_frac,
  input  logic [EXP_W-1:0]  B_exp,
  input  logic [FRAC_W-1:0] B_frac,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [EXP_W-1:0]  Final_exp,
  output logic [FRAC_W:0]   Big_frac,
  output logic [FRAC_W:0]   Small_frac,
  output logic              Sticky,
  output logic              Swapped,
  output logic              Invalid
);
  localparam int CW = $clog2(FRAC_W + 2);
  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [EXP_W-1:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d, exp_q, exp_d;
  logic [FRAC_W-1:0] a_frac_q, a_frac_d, b_frac_q, b_frac_d;
  logic [FRAC_W:0]   big_q, big_d, small_q, small_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_c;
  logic              sticky_q, sticky_d, swapped_q, swapped_d, invalid_q, invalid_d;
  logic              out_valid_q, out_valid_d;
  logic              swap, inv;
  logic [EXP_W-1:0]  big_e, small_e, diff;
  logic [FRAC_W-1:0] big_f, small_f;
  assign swap    = b_exp_q > a_exp_q;
  assign big_e   = swap ? b_exp_q : a_exp_q;
  assign small_e = swap ? a_exp_q : b_exp_q;
  assign big_f   = swap ? b_frac_q : a_frac_q;
  assign small_f = swap ? a_frac_q : b_frac_q;
  assign diff    = big_e - small_e;
  // Beyond FRAC_W+1 shifts the mantissa is already all zeros, so extra cycles buy nothing.
  assign cnt_c   = (int'(diff) > FRAC_W + 1) ? CW'(FRAC_W + 1) : CW'(diff);
  assign inv     = (&a_exp_q) | (&b_exp_q);
  always_comb begin
    state_d     = state_q;
    a_exp_d     = a_exp_q;
    a_frac_d    = a_frac_q;
    b_exp_d     = b_exp_q;
    b_frac_d    = b_frac_q;
    exp_d       = exp_q;
    big_d       = big_q;
    small_d     = small_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    swapped_d   = swapped_q;
    invalid_d   = invalid_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (In_valid) begin
        a_exp_d  = A_exp;
        a_frac_d = A_frac;
        b_exp_d  = B_exp;
        b_frac_d = B_frac;
        state_d  = COMPARE;
      end
      COMPARE: begin
        exp_d     = big_e;
        big_d     = {1'b1, big_f};
        small_d   = {1'b1, small_f};
        sticky_d  = 1'b0;
        swapped_d = swap;
        invalid_d = inv;
        cnt_d     = cnt_c;
        state_d   = (inv || cnt_c == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        small_d  = small_q >> 1;
        sticky_d = sticky_q | small_q[0];
        cnt_d    = cnt_q - 1'b1;
        state_d  = (cnt_q == CW'(1)) ? DONE : SHIFT;
      end
      default: begin
        // Out_valid is registered, so it rises one cycle after entering DONE.
        out_valid_d = 1'b1;
        if (out_valid_q && Out_ready) begin
          out_valid_d = 1'b0;
          exp_d       = '0;
          big_d       = '0;
          small_d     = '0;
          sticky_d    = 1'b0;
          swapped_d   = 1'b0;
          invalid_d   = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_exp_q     <= '0;
      a_frac_q    <= '0;
      b_exp_q     <= '0;
      b_frac_q    <= '0;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      swapped_q   <= 1'b0;
      invalid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_exp_q     <= a_exp_d;
      a_frac_q    <= a_frac_d;
      b_exp_q     <= b_exp_d;
      b_frac_q    <= b_frac_d;
      exp_q       <= exp_d;
      big_q       <= big_d;
      small_q     <= small_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      swapped_q   <= swapped_d;
      invalid_q   <= invalid_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign In_ready   = state_q == IDLE;
  assign Out_valid  = out_valid_q;
  assign Final_exp  = exp_q;
  assign Big_frac   = big_q;
  assign Small_frac = small_q;
  assign Sticky     = sticky_q;
  assign Swapped    = swapped_q;
  assign Invalid    = invalid_q;
endmodule

// File: tb/tb_fp_align_serial.sv
// tb_fp_align_serial: directed vector bench for the alignment stage.
module tb_fp_align_serial;
  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] a_exp, b_exp, final_exp;
  logic [3:0] a_frac, b_frac;
  logic [4:0] big_frac, small_frac;
  logic       sticky, swapped, invalid;
  int tests = 0;
  int fails = 0;
  fp_align_serial dut (
    .clk(clk), .rst_n(rst_n), .In_valid(in_valid), .In_ready(in_ready),
    .A_exp(a_exp), .A_frac(a_frac), .B_exp(b_exp), .B_frac(b_frac),
    .Out_valid(out_valid), .Out_ready(out_ready), .Final_exp(final_exp),
    .Big_frac(big_frac), .Small_frac(small_frac), .Sticky(sticky),
    .Swapped(swapped), .Invalid(invalid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] ae; logic [3:0] af; logic [2:0] be; logic [3:0] bf;
    logic [2:0] exp_e; logic [4:0] big_e; logic [4:0] small_e;
    logic sticky_e; logic swapped_e; logic invalid_e; int lat_e;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] ae, input logic [3:0] af, input logic [2:0] be,
                        input logic [3:0] bf, output int lat);
    chk("in_ready_before_op", 32'(in_ready), 1);
    a_exp = ae; a_frac = af; b_exp = be; b_frac = bf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic chk_result(input vec_t x, input int lat);
    chk("latency", 32'(lat), 32'(x.lat_e));
    chk("final_exp", 32'(final_exp), 32'(x.exp_e));
    chk("big_frac", 32'(big_frac), 32'(x.big_e));
    chk("small_frac", 32'(small_frac), 32'(x.small_e));
    chk("sticky", 32'(sticky), 32'(x.sticky_e));
    chk("swapped", 32'(swapped), 32'(x.swapped_e));
    chk("invalid", 32'(invalid), 32'(x.invalid_e));
    chk("in_ready_busy", 32'(in_ready), 0);
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 0);
    chk("in_ready_after_hs", 32'(in_ready), 1);
    chk("big_frac_idle", 32'(big_frac), 0);
  endtask
  initial begin
    int lat;
    v[0] = '{3'd3, 4'b0000, 3'd1, 4'b1000, 3'd3, 5'b10000, 5'b00110, 1'b0, 1'b0, 1'b0, 4};
    v[1] = '{3'd0, 4'b0001, 3'd6, 4'b1111, 3'd6, 5'b11111, 5'b00000, 1'b1, 1'b1, 1'b0, 7};
    v[2] = '{3'd2, 4'b0101, 3'd2, 4'b1010, 3'd2, 5'b10101, 5'b11010, 1'b0, 1'b0, 1'b0, 2};
    v[3] = '{3'd7, 4'b0000, 3'd1, 4'b0000, 3'd7, 5'b10000, 5'b10000, 1'b0, 1'b0, 1'b1, 2};
    v[4] = '{3'd1, 4'b0011, 3'd2, 4'b0110, 3'd2, 5'b10110, 5'b01001, 1'b1, 1'b1, 1'b0, 3};
    v[5] = '{3'd5, 4'b1111, 3'd1, 4'b0001, 3'd5, 5'b11111, 5'b00001, 1'b1, 1'b0, 1'b0, 6};
    v[6] = '{3'd0, 4'b0000, 3'd5, 4'b0000, 3'd5, 5'b10000, 5'b00000, 1'b1, 1'b1, 1'b0, 7};
    v[7] = '{3'd3, 4'b1100, 3'd7, 4'b1111, 3'd7, 5'b11111, 5'b11100, 1'b0, 1'b1, 1'b1, 2};
    v[8] = '{3'd6, 4'b0000, 3'd0, 4'b0000, 3'd6, 5'b10000, 5'b00000, 1'b1, 1'b0, 1'b0, 7};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_exp = '0; a_frac = '0; b_exp = '0; b_frac = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_outputs", {14'd0, final_exp, big_frac, small_frac, sticky, swapped, invalid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].ae, v[i].af, v[i].be, v[i].bf, lat);
      chk_result(v[i], lat);
      release_out();
    end
    run_op(3'd3, 4'b0000, 3'd1, 4'b1000, lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 1);
      chk_result(v[0], lat);
    end
    release_out();
    a_exp = 3'd0; a_frac = 4'b0001; b_exp = 3'd6; b_frac = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midshift_rst_out_valid", 32'(out_valid), 0);
    chk("midshift_rst_in_ready", 32'(in_ready), 1);
    chk("midshift_rst_small", 32'(small_frac), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(v[0].ae, v[0].af, v[0].be, v[0].bf, lat);
    chk_result(v[0], lat);
    release_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
